vram_arbiter: RTL and testbench

- Shares one single-port synchronous video RAM between the pixel generator's read fetches and CPU-side writes and reads.
- The pixel generator always has priority, because its 3-clk per-pixel fetch sequence cannot stall.
- CPU writes are buffered in a small FIFO and drained in idle clk cycles. A CPU read waits until all earlier writes have drained, which preserves program order.
- Sits between the GPU bus interface, the pixel generator and the VRAM macro.

---
 rtl/gpu_vram_pkg.sv | 19 +
 rtl/vram_write_fifo.sv | 53 +++++
 rtl/vram_arbiter.sv | 141 ++++++++++++++
 tb/tb_vram_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_vram_pkg.sv
// Shared constants and the owner encoding for the VRAM arbitration path.
package gpu_vram_pkg;

  localparam int VRAM_ADDR_W = 13;
  localparam int VRAM_DATA_W = 8;

  localparam logic [VRAM_ADDR_W-1:0] TILE_BASE  = 13'h0000;
  localparam logic [VRAM_ADDR_W-1:0] ATTR_BASE  = 13'h0800;
  localparam logic [VRAM_ADDR_W-1:0] COLOR_BASE = 13'h1000;

  localparam int STARVE_LIMIT = 64;

  typedef enum logic [1:0] {
    OWNER_NONE   = 2'd0,
    OWNER_GPU    = 2'd1,
    OWNER_CPU_RD = 2'd2
  } owner_e;

endpackage

// File: rtl/vram_write_fifo.sv
// CPU write buffer: synchronous FIFO of {addr, data}, no bypass, power-of-two depth.
module vram_write_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] LEVEL_FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LEVEL_FULL);
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = store[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: pixel fetch first, then buffered CPU writes, then CPU reads.
module vram_arbiter
  import gpu_vram_pkg::*;
#(
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int DATA_W     = VRAM_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        gpu_rd_en,
  input  logic [ADDR_W-1:0]           gpu_rd_addr,
  output logic [DATA_W-1:0]           gpu_rd_data,
  output logic                        gpu_rd_valid,
  input  logic                        cpu_wr_valid,
  input  logic [ADDR_W-1:0]           cpu_wr_addr,
  input  logic [DATA_W-1:0]           cpu_wr_data,
  output logic                        cpu_wr_ready,
  input  logic                        cpu_rd_req,
  input  logic [ADDR_W-1:0]           cpu_rd_addr,
  output logic [DATA_W-1:0]           cpu_rd_data,
  output logic                        cpu_rd_done,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        wr_starved
);

  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] STARVE_LAST = CNT_W'(STARVE_LIMIT - 1);

  // owner pipeline | meaning
  // issue_owner    | grant currently driven on the memory port
  // owner          | grant whose read data is on mem_rdata this clk
  owner_e issue_owner;
  owner_e owner;
  owner_e grant_owner;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_data;

  logic               grant_en;
  logic               grant_we;
  logic [ADDR_W-1:0]  grant_addr;
  logic [DATA_W-1:0]  grant_wdata;
  logic               cpu_rd_busy;
  logic [DATA_W-1:0]  cpu_rd_hold;
  logic [CNT_W-1:0]   starve_cnt;

  assign {head_addr, head_data} = fifo_head;
  assign cpu_wr_ready = !fifo_full;
  assign fifo_push    = cpu_wr_valid && cpu_wr_ready;
  assign cpu_rd_busy  = (issue_owner == OWNER_CPU_RD) || (owner == OWNER_CPU_RD);

  vram_write_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_write_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({cpu_wr_addr, cpu_wr_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    grant_owner = OWNER_NONE;
    grant_en    = 1'b0;
    grant_we    = 1'b0;
    grant_addr  = '0;
    grant_wdata = '0;
    fifo_pop    = 1'b0;
    if (gpu_rd_en) begin
      grant_owner = OWNER_GPU;
      grant_en    = 1'b1;
      grant_addr  = gpu_rd_addr;
    end else if (!fifo_empty) begin
      fifo_pop    = 1'b1;
      grant_en    = 1'b1;
      grant_we    = 1'b1;
      grant_addr  = head_addr;
      grant_wdata = head_data;
    end else if (cpu_rd_req && !cpu_rd_busy) begin
      grant_owner = OWNER_CPU_RD;
      grant_en    = 1'b1;
      grant_addr  = cpu_rd_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      issue_owner <= OWNER_NONE;
      owner       <= OWNER_NONE;
      cpu_rd_hold <= '0;
    end else begin
      mem_en      <= grant_en;
      mem_we      <= grant_we;
      mem_addr    <= grant_addr;
      mem_wdata   <= grant_wdata;
      issue_owner <= grant_owner;
      owner       <= issue_owner;
      if (owner == OWNER_CPU_RD) cpu_rd_hold <= mem_rdata;
    end
  end

  // Counts clks with a queued write but no pop; saturates once the flag is set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
      wr_starved <= 1'b0;
    end else if (fifo_empty || fifo_pop) begin
      starve_cnt <= '0;
    end else begin
      if (starve_cnt != STARVE_LAST) starve_cnt <= starve_cnt + 1'b1;
      if (starve_cnt == STARVE_LAST) wr_starved <= 1'b1;
    end
  end

  assign gpu_rd_valid = (owner == OWNER_GPU);
  assign gpu_rd_data  = gpu_rd_valid ? mem_rdata : '0;
  assign cpu_rd_done  = (owner == OWNER_CPU_RD);
  assign cpu_rd_data  = cpu_rd_done ? mem_rdata : cpu_rd_hold;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_vram_arbiter;
  import gpu_vram_pkg::*;

  localparam int AW = 13;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int RND_CYC = 600;

  logic          clk = 1'b0;
  logic          rst;
  logic          gpu_rd_en;
  logic [AW-1:0] gpu_rd_addr;
  logic [DW-1:0] gpu_rd_data;
  logic          gpu_rd_valid;
  logic          cpu_wr_valid;
  logic [AW-1:0] cpu_wr_addr;
  logic [DW-1:0] cpu_wr_data;
  logic          cpu_wr_ready;
  logic          cpu_rd_req;
  logic [AW-1:0] cpu_rd_addr;
  logic [DW-1:0] cpu_rd_data;
  logic          cpu_rd_done;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [2:0]    fifo_level;
  logic          wr_starved;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } gexp_t;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .gpu_rd_en(gpu_rd_en), .gpu_rd_addr(gpu_rd_addr), .gpu_rd_data(gpu_rd_data), .gpu_rd_valid(gpu_rd_valid),
    .cpu_wr_valid(cpu_wr_valid), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data), .cpu_wr_ready(cpu_wr_ready),
    .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr), .cpu_rd_data(cpu_rd_data), .cpu_rd_done(cpu_rd_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .fifo_level(fifo_level), .wr_starved(wr_starved)
  );

  always #5 clk = ~clk;

  // VRAM model: unwritten words read back as the low byte of their address.
  logic [DW-1:0]  vram [1 << AW];
  bit [(1<<AW)-1:0] wrote;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        vram[mem_addr]  <= mem_wdata;
        wrote[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= wrote[mem_addr] ? vram[mem_addr] : mem_addr[DW-1:0];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    gpu_rd_en = 1'b0; gpu_rd_addr = '0;
    cpu_wr_valid = 1'b0; cpu_wr_addr = '0; cpu_wr_data = '0;
    cpu_rd_req = 1'b0; cpu_rd_addr = '0;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    rst = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    got = {gpu_rd_valid, cpu_rd_done, mem_en, mem_we, wr_starved, cpu_wr_ready};
    n_checks++; if (got !== 6'b000001) $display("FAIL reset_flags: got %b want 000001", got); else n_pass++;
    n_checks++; if (fifo_level !== 3'd0) $display("FAIL reset_level: got %0d want 0", fifo_level); else n_pass++;
    n_checks++; if ({mem_addr, mem_wdata, gpu_rd_data, cpu_rd_data} !== '0)
      $display("FAIL reset_data: got %h/%h/%h/%h want 0", mem_addr, mem_wdata, gpu_rd_data, cpu_rd_data); else n_pass++;
    rst = 1'b1;
    tick();
    got = {gpu_rd_valid, cpu_rd_done, mem_en, mem_we, wr_starved, cpu_wr_ready};
    n_checks++; if (got !== 6'b000001) $display("FAIL post_reset_flags: got %b want 000001", got); else n_pass++;
  endtask

  task automatic test_gpu_burst();
    logic          exp_v;
    logic [DW-1:0] exp_d;
    logic          we_seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      exp_v = (c >= 2 && c <= 4);
      n_checks++; if (gpu_rd_valid !== exp_v) $display("FAIL gpu_burst_valid c%0d: got %b want %b", c, gpu_rd_valid, exp_v); else n_pass++;
      if (exp_v) begin
        exp_d = 8'(8'h10 + c - 2);
        n_checks++; if (gpu_rd_data !== exp_d) $display("FAIL gpu_burst_data c%0d: got %h want %h", c, gpu_rd_data, exp_d); else n_pass++;
      end
      if (mem_we) we_seen = 1'b1;
      gpu_rd_en   = (c < 3);
      gpu_rd_addr = TILE_BASE + 13'(16 + c);
    end
    gpu_rd_en = 1'b0;
    n_checks++; if (we_seen !== 1'b0) $display("FAIL gpu_burst_no_write: got mem_we %b want 0", we_seen); else n_pass++;
  endtask

  task automatic test_fifo_fill();
    logic [DW-1:0] d [5];
    logic          exp_r;
    for (int i = 0; i < 5; i++) begin
      tick();
      d[i] = 8'($urandom);
      gpu_rd_en = 1'b1;
      cpu_wr_valid = 1'b1;
      cpu_wr_addr = ATTR_BASE + 13'h100 + 13'(i);
      cpu_wr_data = d[i];
      exp_r = (i < 4);
      n_checks++; if (cpu_wr_ready !== exp_r) $display("FAIL fill_ready i%0d: got %b want %b", i, cpu_wr_ready, exp_r); else n_pass++;
    end
    tick();
    cpu_wr_valid = 1'b0;
    n_checks++; if (fifo_level !== 3'd4) $display("FAIL fill_level: got %0d want 4", fifo_level); else n_pass++;
    tick();
    gpu_rd_en = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      n_checks++;
      if (!(mem_en && mem_we) || mem_addr !== ATTR_BASE + 13'h100 + 13'(j) || mem_wdata !== d[j])
        $display("FAIL drain_order j%0d: got en%b we%b %h=%h want %h=%h", j, mem_en, mem_we, mem_addr, mem_wdata,
                 ATTR_BASE + 13'h100 + 13'(j), d[j]);
      else n_pass++;
    end
    tick();
    n_checks++; if (fifo_level !== 3'd0 || mem_we !== 1'b0) $display("FAIL drain_done: got level %0d we %b want 0 0", fifo_level, mem_we); else n_pass++;
    idle_inputs();
    repeat (3) tick();
  endtask

  task automatic test_read_after_write();
    int wr_cyc = -1, rd_cyc = -1, done_cyc = -1, n_done = 0;
    logic [DW-1:0] got_d = '0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (mem_en && mem_we && mem_addr == ATTR_BASE) wr_cyc = c;
      if (mem_en && !mem_we && mem_addr == ATTR_BASE) rd_cyc = c;
      if (cpu_rd_done) begin
        n_done++;
        if (done_cyc < 0) begin done_cyc = c; got_d = cpu_rd_data; end
        cpu_rd_req = 1'b0;
      end
      gpu_rd_addr = TILE_BASE + 13'h020;
      case (c)
        0: begin gpu_rd_en = 1'b1; cpu_wr_valid = 1'b1; cpu_wr_addr = ATTR_BASE; cpu_wr_data = 8'h5A; end
        1: begin gpu_rd_en = 1'b0; cpu_wr_valid = 1'b0; cpu_rd_req = 1'b1; cpu_rd_addr = ATTR_BASE; end
        2: gpu_rd_en = 1'b1;
        default: gpu_rd_en = 1'b0;
      endcase
    end
    n_checks++; if (done_cyc < 0) $display("FAIL raw_timeout: got no cpu_rd_done want one within 20 clks"); else n_pass++;
    n_checks++; if (n_done != 1) $display("FAIL raw_done_count: got %0d want 1", n_done); else n_pass++;
    n_checks++; if (wr_cyc < 0 || rd_cyc <= wr_cyc) $display("FAIL raw_order: got write clk %0d read clk %0d want write first", wr_cyc, rd_cyc); else n_pass++;
    n_checks++; if (got_d !== 8'h5A) $display("FAIL raw_data: got %h want 5a", got_d); else n_pass++;
    n_checks++; if (cpu_rd_data !== 8'h5A) $display("FAIL raw_hold: got %h want 5a", cpu_rd_data); else n_pass++;
    idle_inputs();
    repeat (2) tick();
  endtask

  task automatic test_full_push_pop();
    int   nwr = 0;
    logic saw_rej = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      gpu_rd_en = 1'b1; cpu_wr_valid = 1'b1;
      cpu_wr_addr = ATTR_BASE + 13'h200 + 13'(i); cpu_wr_data = 8'(8'h30 + i);
    end
    tick();
    cpu_wr_valid = 1'b0;
    n_checks++; if (fifo_level !== 3'd4 || cpu_wr_ready !== 1'b0) $display("FAIL full_state: got level %0d ready %b want 4 0", fifo_level, cpu_wr_ready); else n_pass++;
    tick();
    gpu_rd_en = 1'b0; cpu_wr_valid = 1'b1; cpu_wr_addr = ATTR_BASE + 13'h2FF; cpu_wr_data = 8'hEE;
    tick();
    cpu_wr_valid = 1'b0;
    n_checks++; if (fifo_level !== 3'd3 || cpu_wr_ready !== 1'b1) $display("FAIL push_pop_full: got level %0d ready %b want 3 1", fifo_level, cpu_wr_ready); else n_pass++;
    for (int c = 0; c < 6; c++) begin
      if (mem_en && mem_we) begin
        nwr++;
        if (mem_wdata == 8'hEE) saw_rej = 1'b1;
      end
      tick();
    end
    n_checks++; if (nwr != 4 || saw_rej) $display("FAIL rejected_push: got %0d writes rejected_seen %b want 4 0", nwr, saw_rej); else n_pass++;
    idle_inputs();
    repeat (2) tick();
  endtask

  task automatic test_starve();
    for (int c = 0; c <= 65; c++) begin
      tick();
      if (c == 64) begin
        n_checks++; if (wr_starved !== 1'b0) $display("FAIL starve_early: got %b want 0 at clk 64", wr_starved); else n_pass++;
      end
      if (c == 65) begin
        n_checks++; if (wr_starved !== 1'b1) $display("FAIL starve_set: got %b want 1 at clk 65", wr_starved); else n_pass++;
      end
      gpu_rd_en = 1'b1;
      gpu_rd_addr = TILE_BASE + 13'(c);
      cpu_wr_valid = (c == 0);
      cpu_wr_addr = ATTR_BASE + 13'h300;
      cpu_wr_data = 8'h77;
    end
    gpu_rd_en = 1'b0;
    repeat (4) tick();
    n_checks++; if (wr_starved !== 1'b1 || fifo_level !== 3'd0) $display("FAIL starve_sticky: got %b level %0d want 1 0", wr_starved, fifo_level); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    logic pulse_seen = 1'b0;
    tick();
    cpu_rd_req = 1'b1; cpu_rd_addr = ATTR_BASE + 13'h400;
    cpu_wr_valid = 1'b1; cpu_wr_addr = ATTR_BASE + 13'h401; cpu_wr_data = 8'h11;
    tick();
    cpu_wr_valid = 1'b0;
    n_checks++; if (!(mem_en && !mem_we) || mem_addr !== ATTR_BASE + 13'h400 || fifo_level !== 3'd1)
      $display("FAIL mid_granted: got en%b we%b addr %h level %0d want read of %h level 1", mem_en, mem_we, mem_addr, fifo_level, ATTR_BASE + 13'h400);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (fifo_level !== 3'd0 || cpu_wr_ready !== 1'b1) $display("FAIL mid_fifo: got level %0d ready %b want 0 1", fifo_level, cpu_wr_ready); else n_pass++;
    n_checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0 || cpu_rd_done !== 1'b0 || wr_starved !== 1'b0)
      $display("FAIL mid_outputs: got en%b we%b %h %h done%b starved%b want all 0", mem_en, mem_we, mem_addr, mem_wdata, cpu_rd_done, wr_starved);
    else n_pass++;
    cpu_rd_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (cpu_rd_done || gpu_rd_valid) pulse_seen = 1'b1;
    end
    n_checks++; if (pulse_seen !== 1'b0) $display("FAIL mid_no_pulse: got pulse %b want 0", pulse_seen); else n_pass++;
  endtask

  task automatic test_random();
    gexp_t               gq[$];
    gexp_t               e;
    logic [AW+DW-1:0]    wq[$];
    logic [DW-1:0]       shadow [16];
    logic                rd_pend = 1'b0;
    logic                done_now;
    logic                active;
    logic [DW-1:0]       rd_exp = '0;
    int                  rd_age = 0;
    int                  off;
    for (int i = 0; i < 16; i++) shadow[i] = 8'(COLOR_BASE + 13'(i));
    for (int c = 0; c < RND_CYC + 40; c++) begin
      tick();
      if (gq.size() != 0 && gq[0].due == c) begin
        n_checks++;
        if (gpu_rd_valid !== 1'b1 || gpu_rd_data !== gq[0].data)
          $display("FAIL rnd_gpu c%0d: got v%b %h want v1 %h", c, gpu_rd_valid, gpu_rd_data, gq[0].data);
        else n_pass++;
        void'(gq.pop_front());
      end else begin
        n_checks++; if (gpu_rd_valid !== 1'b0) $display("FAIL rnd_gpu_spurious c%0d: got valid %b want 0", c, gpu_rd_valid); else n_pass++;
      end
      if (mem_en && mem_we) begin
        n_checks++;
        if (wq.size() == 0) $display("FAIL rnd_write c%0d: got %h=%h want no write", c, mem_addr, mem_wdata);
        else begin
          if ({mem_addr, mem_wdata} !== wq[0]) $display("FAIL rnd_write c%0d: got %h want %h", c, {mem_addr, mem_wdata}, wq[0]);
          else n_pass++;
          void'(wq.pop_front());
        end
      end
      done_now = cpu_rd_done;
      if (done_now) begin
        n_checks++;
        if (!rd_pend || cpu_rd_data !== rd_exp) $display("FAIL rnd_cpu_rd c%0d: got pend%b %h want %h", c, rd_pend, cpu_rd_data, rd_exp);
        else n_pass++;
        rd_pend = 1'b0; cpu_rd_req = 1'b0;
      end else if (rd_pend) begin
        rd_age++;
        if (rd_age > 300) begin
          n_checks++; $display("FAIL rnd_cpu_rd_timeout c%0d: got no done want done", c);
          rd_pend = 1'b0; cpu_rd_req = 1'b0;
        end
      end
      active = (c < RND_CYC);
      gpu_rd_en = active && ($urandom_range(0, 99) < 55);
      gpu_rd_addr = TILE_BASE + 13'($urandom_range(0, 2047));
      if (gpu_rd_en) begin
        e.due = c + 2; e.data = gpu_rd_addr[DW-1:0];
        gq.push_back(e);
      end
      cpu_wr_valid = 1'b0;
      if (active && !rd_pend && $urandom_range(0, 99) < 40) begin
        off = int'($urandom_range(0, 15));
        cpu_wr_valid = 1'b1; cpu_wr_addr = COLOR_BASE + 13'(off); cpu_wr_data = 8'($urandom);
        if (cpu_wr_ready) begin
          wq.push_back({cpu_wr_addr, cpu_wr_data});
          shadow[off] = cpu_wr_data;
        end
      end else if (active && !rd_pend && !done_now && $urandom_range(0, 99) < 12) begin
        off = int'($urandom_range(0, 15));
        rd_pend = 1'b1; rd_age = 0; rd_exp = shadow[off];
        cpu_rd_req = 1'b1; cpu_rd_addr = COLOR_BASE + 13'(off);
      end
    end
    n_checks++; if (wq.size() != 0 || gq.size() != 0 || rd_pend)
      $display("FAIL rnd_leftover: got writes %0d gpu %0d read %b want 0 0 0", wq.size(), gq.size(), rd_pend);
    else n_pass++;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_gpu_burst();
    test_fifo_fill();
    test_read_after_write();
    test_full_push_pop();
    test_starve();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
